// File: rtl/ucore_mem_arbiter.sv
// ucore_mem_arbiter: round-robin arbiter that gives N_REQ microcoded cores
// single-outstanding access to one shared memory port, with a response timeout.
module ucore_mem_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    aresetn,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ-1:0]        req_write,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_wdata,
  output logic [N_REQ-1:0]        req_ready,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]       rsp_rdata,
  output logic                    rsp_error,
  output logic                    mem_valid,
  output logic                    mem_write,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [DATA_W-1:0]       mem_wdata,
  input  logic                    mem_ready,
  input  logic                    mem_rsp_valid,
  input  logic [DATA_W-1:0]       mem_rdata,
  output logic                    busy,
  output logic [2:0]              grant_id
);

  localparam int unsigned GID_W = 3;
  localparam int unsigned CNT_W = 8;
  // wide enough to hold last_grant + N_REQ before the modulo wrap
  localparam int unsigned SUM_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t              state_q, state_n;
  logic [GID_W-1:0]    last_grant_q, last_grant_n;
  logic [GID_W-1:0]    grant_q, grant_n;
  logic                wr_q, wr_n;
  logic [ADDR_W-1:0]   addr_q, addr_n;
  logic [DATA_W-1:0]   wdata_q, wdata_n;
  logic [CNT_W-1:0]    cnt_q, cnt_n;
  logic [DATA_W-1:0]   rdata_q, rdata_n;
  logic                err_q, err_n;
  logic                mem_valid_q;
  logic [N_REQ-1:0]    rsp_valid_q, rsp_valid_n;
  logic                busy_q;

  logic                win_found_c;
  logic [GID_W-1:0]    winner_c;
  logic [SUM_W-1:0]    cand_c;
  logic                win_write_c;
  logic [ADDR_W-1:0]   win_addr_c;
  logic [DATA_W-1:0]   win_wdata_c;
  logic [N_REQ-1:0]    req_ready_c;

  // Round-robin search: first pending requester upward from last_grant+1 mod N_REQ
  always_comb begin
    win_found_c = 1'b0;
    winner_c    = '0;
    cand_c      = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand_c = SUM_W'(last_grant_q) + SUM_W'(k);
      if (cand_c >= SUM_W'(N_REQ)) begin
        cand_c = cand_c - SUM_W'(N_REQ);
      end
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (!win_found_c && (cand_c == SUM_W'(i)) && req_valid[i]) begin
          win_found_c = 1'b1;
          winner_c    = GID_W'(i);
        end
      end
    end
  end

  // Select the winning requester's command fields
  always_comb begin
    win_write_c = 1'b0;
    win_addr_c  = '0;
    win_wdata_c = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (winner_c == GID_W'(i)) begin
        win_write_c = req_write[i];
        win_addr_c  = req_addr[i*ADDR_W +: ADDR_W];
        win_wdata_c = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state and datapath updates for the IDLE/ISSUE/WAIT/RESP sequence
  always_comb begin
    state_n      = state_q;
    last_grant_n = last_grant_q;
    grant_n      = grant_q;
    wr_n         = wr_q;
    addr_n       = addr_q;
    wdata_n      = wdata_q;
    cnt_n        = cnt_q;
    rdata_n      = rdata_q;
    err_n        = err_q;
    req_ready_c  = '0;
    rsp_valid_n  = '0;

    case (state_q)
      IDLE: begin
        // ready is held low while reset is asserted so nothing looks accepted
        if (aresetn && win_found_c) begin
          for (int unsigned i = 0; i < N_REQ; i++) begin
            req_ready_c[i] = (winner_c == GID_W'(i));
          end
          grant_n = winner_c;
          wr_n    = win_write_c;
          addr_n  = win_addr_c;
          wdata_n = win_wdata_c;
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_ready) begin
          cnt_n   = '0;
          state_n = WAIT;
        end
      end
      WAIT: begin
        // a real response beats a timeout landing in the same cycle
        if (mem_rsp_valid) begin
          rdata_n = mem_rdata;
          err_n   = 1'b0;
          state_n = RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          rdata_n = '0;
          err_n   = 1'b1;
          state_n = RESP;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        last_grant_n = grant_q;
        state_n      = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    if (state_n == RESP) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        rsp_valid_n[i] = (grant_n == GID_W'(i));
      end
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= IDLE;
      last_grant_q <= GID_W'(N_REQ - 1);
      grant_q      <= '0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_n;
      last_grant_q <= last_grant_n;
      grant_q      <= grant_n;
      wr_q         <= wr_n;
      addr_q       <= addr_n;
      wdata_q      <= wdata_n;
      cnt_q        <= cnt_n;
      rdata_q      <= rdata_n;
      err_q        <= err_n;
    end
  end

  // Registered status strobes, decoded from the next state
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      mem_valid_q <= 1'b0;
      rsp_valid_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      mem_valid_q <= (state_n == ISSUE);
      rsp_valid_q <= rsp_valid_n;
      busy_q      <= (state_n != IDLE);
    end
  end

  assign req_ready = req_ready_c;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_error = err_q;
  assign mem_valid = mem_valid_q;
  assign mem_write = wr_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = busy_q;
  assign grant_id  = grant_q;

endmodule

// File: tb/tb_ucore_mem_arbiter.sv
// tb_ucore_mem_arbiter: directed and randomized checks of ucore_mem_arbiter
// against a transaction-level model, with a scoreboard for responses.
module tb_ucore_mem_arbiter;

  localparam int N     = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int TO    = 4;
  localparam int NEVER = 1000;

  logic            clk = 1'b0;
  logic            aresetn;
  logic [N-1:0]    req_valid, req_write, req_ready, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0]   rsp_rdata, mem_wdata, mem_rdata;
  logic            rsp_error, mem_valid, mem_write, mem_ready, mem_rsp_valid, busy;
  logic [AW-1:0]   mem_addr;
  logic [2:0]      grant_id;

  ucore_mem_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .aresetn(aresetn),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .mem_valid(mem_valid), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // expected response: requester, data, error flag and the cycle it must appear
  typedef struct {
    int          id;
    logic [DW-1:0] data;
    logic        err;
    int          at;
  } rsp_t;
  rsp_t sb[$];

  // requester model
  bit            pend[N];
  bit            p_wr[N];
  logic [AW-1:0] p_addr[N];
  logic [DW-1:0] p_wdata[N];

  // transaction-level model: 0 idle, 1 issuing, 2 waiting for memory, 3 responding
  int            ph = 0;
  int            last_g = N - 1;
  int            cur_id = 0;
  logic          cur_wr;
  logic [AW-1:0] cur_addr;
  logic [DW-1:0] cur_wdata;
  int            ready_left, rsp_d, w;
  logic [DW-1:0] rsp_data_m;
  int            issue_cycles;
  int            grants[$];

  // policies
  bit            auto_req = 1'b0;
  bit            refill   = 1'b0;
  int            pol_ready = -1;
  int            pol_rsp   = -1;
  bit            pol_data_set = 1'b0;
  logic [DW-1:0] pol_data = '0;

  task automatic new_req(input int i);
    pend[i]    = 1'b1;
    p_wr[i]    = 1'($urandom_range(0, 1));
    p_addr[i]  = $urandom;
    p_wdata[i] = $urandom;
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      req_valid[i]               = pend[i];
      req_write[i]               = p_wr[i];
      req_addr[i*AW +: AW]       = p_addr[i];
      req_wdata[i*DW +: DW]      = p_wdata[i];
    end
  endtask

  function automatic int rr_pick();
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (last_g + k) % N;
      if (pend[i]) return i;
    end
    return -1;
  endfunction

  // One clock of stimulus plus the checks owned by the driver side
  task automatic step();
    int            ph0;
    int            exp_w;
    logic [N-1:0]  exp_rdy;
    rsp_t          e;
    @(negedge clk);
    ph0   = ph;
    exp_w = -1;
    if (auto_req) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i]) begin
          if ($urandom_range(0, 3) == 0) new_req(i);
        end else if ($urandom_range(0, 15) == 0) begin
          pend[i] = 1'b0;
        end
      end
    end
    drive_reqs();
    mem_ready     = 1'($urandom_range(0, 1));
    mem_rsp_valid = ($urandom_range(0, 3) == 0);
    mem_rdata     = $urandom;

    check("busy", 64'(busy), 64'(ph0 != 0));
    check("mem_valid", 64'(mem_valid), 64'(ph0 == 1));
    if (ph0 != 0) check("grant_id", 64'(grant_id), 64'(cur_id));

    case (ph0)
      1: begin
        issue_cycles++;
        check("mem_addr", 64'(mem_addr), 64'(cur_addr));
        check("mem_write", 64'(mem_write), 64'(cur_wr));
        check("mem_wdata", 64'(mem_wdata), 64'(cur_wdata));
        mem_ready = (ready_left == 0);
        if (ready_left > 0) begin
          ready_left--;
        end else begin
          ph = 2;
          w  = 0;
          rsp_d = (pol_rsp >= 0) ? pol_rsp : int'($urandom_range(0, TO + 3));
          rsp_data_m = pol_data_set ? pol_data : DW'($urandom);
          e.id   = cur_id;
          e.err  = (rsp_d > TO);
          e.data = (rsp_d > TO) ? '0 : rsp_data_m;
          e.at   = cyc + 2 + ((rsp_d > TO) ? TO : rsp_d);
          sb.push_back(e);
        end
      end
      2: begin
        mem_rsp_valid = (w == rsp_d);
        if (mem_rsp_valid) mem_rdata = rsp_data_m;
        if (w == rsp_d || w == TO) ph = 3;
        else w++;
      end
      3: begin
        last_g = cur_id;
        ph     = 0;
      end
      default: ;
    endcase

    #1;
    exp_rdy = '0;
    if (ph0 == 0) begin
      exp_w = rr_pick();
      if (exp_w >= 0) exp_rdy[exp_w] = 1'b1;
    end
    check("req_ready", 64'(req_ready), 64'(exp_rdy));
    if (ph0 == 0 && exp_w >= 0) begin
      cur_id       = exp_w;
      cur_wr       = p_wr[exp_w];
      cur_addr     = p_addr[exp_w];
      cur_wdata    = p_wdata[exp_w];
      grants.push_back(exp_w);
      ph           = 1;
      issue_cycles = 0;
      ready_left   = (pol_ready >= 0) ? pol_ready : int'($urandom_range(0, 3));
      if (refill) new_req(exp_w);
      else pend[exp_w] = 1'b0;
    end
  endtask

  task automatic drain();
    int bud;
    refill = 1'b0;
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    bud = 0;
    while (ph != 0 && bud < 60) begin
      step();
      bud++;
    end
    check("drain_idle", 64'(ph), 64'(0));
    step();
  endtask

  task automatic check_reset_outputs();
    check("rst_req_ready", 64'(req_ready), 64'(0));
    check("rst_rsp_valid_out", 64'(rsp_valid), 64'(0));
    check("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
    check("rst_rsp_error", 64'(rsp_error), 64'(0));
    check("rst_mem_valid", 64'(mem_valid), 64'(0));
    check("rst_mem_write", 64'(mem_write), 64'(0));
    check("rst_mem_addr", 64'(mem_addr), 64'(0));
    check("rst_mem_wdata", 64'(mem_wdata), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_grant_id", 64'(grant_id), 64'(0));
  endtask

  // Reset while requesters 1 and 3 are pending; release with a late memory response
  task automatic apply_reset(input int cycles);
    @(negedge clk);
    #3;
    aresetn = 1'b0;
    sb.delete();
    ph     = 0;
    last_g = N - 1;
    for (int i = 0; i < N; i++) pend[i] = (i == 1 || i == 3);
    drive_reqs();
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    #1;
    check_reset_outputs();
    repeat (cycles) @(negedge clk);
    #3;
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    drive_reqs();
    mem_rsp_valid = 1'b1;
    mem_rdata     = $urandom;
    aresetn       = 1'b1;
  endtask

  // Response monitor: pops the scoreboard whenever the DUT strobes rsp_valid
  initial begin : monitor
    rsp_t          e;
    logic [N-1:0]  oh;
    logic [DW-1:0] held_d;
    logic          held_e;
    held_d = '0;
    held_e = 1'b0;
    forever begin
      @(negedge clk);
      if (!aresetn) begin
        held_d = '0;
        held_e = 1'b0;
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      end else begin
        if (sb.size() > 0 && sb[0].at < cyc) begin
          check("rsp_missing_cycle", 64'(cyc), 64'(sb[0].at));
          void'(sb.pop_front());
        end
        if (rsp_valid != '0) begin
          if (sb.size() == 0) begin
            check("rsp_unexpected", 64'(rsp_valid), 64'(0));
          end else begin
            e  = sb.pop_front();
            oh = '0;
            oh[e.id] = 1'b1;
            check("rsp_valid", 64'(rsp_valid), 64'(oh));
            check("rsp_rdata", 64'(rsp_rdata), 64'(e.data));
            check("rsp_error", 64'(rsp_error), 64'(e.err));
            check("rsp_cycle", 64'(cyc), 64'(e.at));
            held_d = e.data;
            held_e = e.err;
          end
        end else begin
          check("rsp_rdata_hold", 64'(rsp_rdata), 64'(held_d));
          check("rsp_error_hold", 64'(rsp_error), 64'(held_e));
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    int exp_rr[5];
    int bud;
    exp_rr = '{0, 1, 2, 3, 0};
    aresetn       = 1'b0;
    req_valid     = '0;
    req_write     = '0;
    req_addr      = '0;
    req_wdata     = '0;
    mem_ready     = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rdata     = '0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0; p_wr[i] = 1'b0; p_addr[i] = '0; p_wdata[i] = '0;
    end
    apply_reset(3);
    step();

    // round-robin with all four requests held continuously
    pol_ready = 0; pol_rsp = 0;
    grants.delete();
    for (int i = 0; i < N; i++) new_req(i);
    refill = 1'b1;
    bud = 0;
    while (grants.size() < 5 && bud < 100) begin
      step();
      bud++;
    end
    drain();
    check("rr_grant_count", 64'(grants.size()), 64'(5));
    for (int k = 0; k < 5 && k < grants.size(); k++) check("rr_order", 64'(grants[k]), 64'(exp_rr[k]));

    // single read of 0x100 returning 0xDEADBEEF at minimum latency
    pend[0] = 1'b1; p_wr[0] = 1'b0; p_addr[0] = 32'h100; p_wdata[0] = '0;
    pol_data_set = 1'b1; pol_data = 32'hDEADBEEF;
    step();
    drain();
    pol_data_set = 1'b0;

    // backpressure: mem_ready low for 5 cycles
    pol_ready = 5;
    new_req(2);
    step();
    drain();
    check("backpressure_issue_cycles", 64'(issue_cycles), 64'(6));
    pol_ready = 0;

    // timeout with no memory response
    pol_rsp = NEVER;
    new_req(3);
    step();
    drain();

    // response arriving exactly when the counter reaches TIMEOUT
    pol_rsp = TO;
    new_req(1);
    step();
    drain();

    // reset while waiting for memory, then requesters 1 and 3 compete
    pol_rsp = NEVER;
    new_req(2);
    bud = 0;
    while (ph != 2 && bud < 20) begin
      step();
      bud++;
    end
    step();
    check("reached_wait", 64'(ph), 64'(2));
    apply_reset(2);
    step();
    pol_rsp = 0;
    grants.delete();
    new_req(1);
    new_req(3);
    step();
    check("post_reset_grants", 64'(grants.size()), 64'(1));
    if (grants.size() > 0) check("post_reset_first_grant", 64'(grants[0]), 64'(1));
    drain();

    // randomized traffic
    pol_ready = -1; pol_rsp = -1;
    auto_req  = 1'b1;
    repeat (1500) step();
    auto_req  = 1'b0;
    drain();
    repeat (3) step();
    check("scoreboard_empty", 64'(sb.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ucore_mem_arbiter.md
UCORE_MEM_ARBITER -- requirements
Module: ucore_mem_arbiter

Interface
REQ-001 SHALL have parameters (name, default, meaning):
- N_REQ, 4, number of microcoded core requesters; legal range 2..8.
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT, 255, maximum number of WAIT cycles before an error response; legal range 1..255.

REQ-002 SHALL have ports (name, direction, width, meaning):
- clk, in, 1, clock; all state updates on the rising edge.
- aresetn, in, 1, reset: asynchronous, active-low.
- req_valid, in, N_REQ, per-requester request pending.
- req_write, in, N_REQ, per-requester 1=write, 0=read.
- req_addr, in, N_REQ*ADDR_W, packed addresses; requester i occupies slice i.
- req_wdata, in, N_REQ*DATA_W, packed write data; requester i occupies slice i.
- req_ready, out, N_REQ, one-hot request accept.
- rsp_valid, out, N_REQ, one-hot response strobe.
- rsp_rdata, out, DATA_W, response read data, shared by all requesters.
- rsp_error, out, 1, response is a timeout error.
- mem_valid, out, 1, shared memory request valid.
- mem_write, out, 1, shared memory write enable.
- mem_addr, out, ADDR_W, shared memory address.
- mem_wdata, out, DATA_W, shared memory write data.
- mem_ready, in, 1, memory accepts the request.
- mem_rsp_valid, in, 1, memory response valid.
- mem_rdata, in, DATA_W, memory read data.
- busy, out, 1, arbiter is in any state other than IDLE.
- grant_id, out, 3, index of the current or last granted requester.

Function
REQ-003 SHALL implement a four-state FSM: IDLE, ISSUE, WAIT, RESP.
REQ-004 In IDLE with any req_valid bit set, SHALL select the winner round-robin, searching upward from last_grant+1 modulo N_REQ.
REQ-005 In that IDLE cycle, SHALL do all of the following:
- assert req_ready[winner] combinationally, with no other req_ready bit set;
- latch the winner's write, address and wdata fields;
- set grant_id to the winner;
- go to ISSUE on the next edge.
REQ-006 req_ready SHALL be all-zero in every state except IDLE; requesters not granted keep their requests pending.
REQ-007 In ISSUE, SHALL assert mem_valid and drive mem_write, mem_addr and mem_wdata from the latched fields, holding them stable until mem_ready is sampled high; then go to WAIT.
REQ-008 On entry to WAIT, SHALL clear the 8-bit timeout counter; SHALL increment it by one each WAIT cycle in which mem_rsp_valid is low.
REQ-009 In WAIT with mem_rsp_valid high, SHALL capture mem_rdata, clear the error flag and go to RESP.
REQ-010 In WAIT with the counter equal to TIMEOUT and mem_rsp_valid low, SHALL set rdata to 0, set the error flag and go to RESP.
REQ-011 If mem_rsp_valid and the timeout condition occur in the same cycle, the real response SHALL win: no error, captured data returned.
REQ-012 mem_rsp_valid sampled in any state other than WAIT SHALL be ignored and SHALL have no effect on state or data.
REQ-013 In RESP, for exactly one cycle, SHALL:
- assert rsp_valid[grant_id];
- drive rsp_rdata and rsp_error from the captured values;
- update last_grant to grant_id;
- go to IDLE.
REQ-014 rsp_rdata and rsp_error SHALL hold their last values outside RESP; rsp_valid SHALL be zero outside RESP.
REQ-015 Minimum latency SHALL be 3 cycles, from the req_ready cycle (cycle 0) to rsp_valid (cycle 3), when mem_ready is high in cycle 1 and mem_rsp_valid is high in cycle 2.
REQ-016 SHALL allow only one transaction outstanding; a new grant is possible at the earliest in the cycle after RESP.
REQ-017 busy SHALL be 1 in ISSUE, WAIT and RESP, and 0 in IDLE.
REQ-018 req_valid bits dropped while not granted SHALL simply be skipped by the next arbitration; no sticky request state.

Reset
REQ-019 While aresetn is low, the block SHALL asynchronously force:
- state to IDLE;
- last_grant to N_REQ-1, so requester 0 wins first;
- grant_id, latched fields, counter, rsp_rdata and rsp_error to 0;
- mem_valid, rsp_valid and busy to 0.
REQ-020 Reset asserted mid-transaction SHALL abandon the transaction: no rsp_valid is produced, and a late mem_rsp_valid after reset is ignored per REQ-012.
REQ-021 The first arbitration after reset deassertion SHALL occur on the first clk edge at which req_valid is non-zero in IDLE.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Single read: req_valid=0001, addr 0x100, mem_ready high at once, mem_rsp_valid one cycle later with rdata 0xDEADBEEF -> req_ready=0001 at cycle 0, mem_valid at cycle 1, rsp_valid=0001 with rdata 0xDEADBEEF at cycle 3, rsp_error=0.
- Round-robin: req_valid=1111 held continuously -> grant order 0,1,2,3,0; no requester starved.
- Backpressure: mem_ready low for 5 cycles -> mem_valid, mem_addr and mem_wdata stable for 6 cycles; single acceptance.
- Timeout: TIMEOUT=4, no mem_rsp_valid -> rsp_valid with rsp_error=1 and rdata 0 after 4 WAIT cycles.
- Collision: mem_rsp_valid arrives in the same cycle the counter equals TIMEOUT -> rsp_error=0 and data returned.
- Mid-op reset: assert aresetn low while in WAIT -> all outputs 0 and no rsp_valid; afterwards req_valid=1010 grants requester 1 first.
